jtkcpu_simctrl: RTL and testbench

Memory-mapped simulation-control and interrupt-source peripheral on the jtkcpu data bus, downstream of the CPU's addr/dout/we outputs. It decodes a 4-byte register window and drives the CPU's nmi_n/firq_n/irq_n inputs from software levels and a programmable 16-bit timer. It also sequences end-of-simulation: a delayed finish strobe carrying a pass/fail verdict, plus a cycle timeout watchdog. The bench or SoC top instantiates it in place of ad-hoc control logic.

---
 rtl/jtkcpu_simctrl.sv | 144 ++++++++++++++
 tb/tb_jtkcpu_simctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_simctrl.sv
// Simulation-control and interrupt-source peripheral for the jtkcpu bus.
// Provides software IRQ levels, a reloadable 16-bit timer, delayed finish and a watchdog.
module jtkcpu_simctrl #(
    parameter int unsigned FINISH_DLY = 20,
    parameter int unsigned TIMEOUT    = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       nmi_n,
    output logic       firq_n,
    output logic       irq_n,
    output logic       finish,
    output logic       pass,
    output logic       timeout
);
    localparam logic [7:0]  FDLY = 8'(FINISH_DLY);
    localparam logic [31:0] TOUT = 32'(TIMEOUT);

    logic        sw_nmi, sw_firq, sw_irq, good, finishing;
    logic        tmr_pend, tmr_run, route, autorld;
    logic [15:0] rld, count;
    logic [7:0]  fcnt;
    logic [31:0] wdog, wdog_nxt;
    logic        wr, wr_ctrl, wr_tctrl, tick, expire, fin_hit, wd_hit;

    assign wr       = cs & we & cen & ~finish;
    assign wr_ctrl  = wr && addr == 2'd0;
    assign wr_tctrl = wr && addr == 2'd3;
    assign tick     = cen & tmr_run;
    assign expire   = tick && count == 16'd1;
    assign wdog_nxt = (&wdog) ? wdog : wdog + 32'd1;
    assign wd_hit   = TOUT != '0 && wdog_nxt == TOUT;
    assign fin_hit  = finishing && fcnt == 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_nmi  <= 1'b0;
            sw_firq <= 1'b0;
            sw_irq  <= 1'b0;
            good    <= 1'b0;
            rld     <= '0;
        end else if (wr) begin
            case (addr)
                2'd0: {sw_nmi, sw_firq, sw_irq, good} <= {din[7:5], din[1]};
                2'd1: rld[7:0]  <= din;
                2'd2: rld[15:8] <= din;
                default: ;
            endcase
        end
    end

    // A TCTRL write overrides the tick for run/count, but an expiry in the
    // same cycle still sets tmr_pend ahead of any clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            tmr_run  <= 1'b0;
            tmr_pend <= 1'b0;
            route    <= 1'b0;
            autorld  <= 1'b0;
        end else begin
            if (wr_tctrl) begin
                route   <= din[2];
                autorld <= din[1];
                if (din[0]) begin
                    count   <= rld;
                    tmr_run <= rld != '0;
                end else begin
                    tmr_run <= 1'b0;
                end
            end else if (tick) begin
                if (count == 16'd1) begin
                    if (autorld && rld != '0) count <= rld;
                    else begin
                        count   <= '0;
                        tmr_run <= 1'b0;
                    end
                end else begin
                    count <= count - 16'd1;
                end
            end
            if (expire) tmr_pend <= 1'b1;
            else if (wr_tctrl && din[7]) tmr_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finishing <= 1'b0;
            fcnt      <= '0;
            wdog      <= '0;
            finish    <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            wdog <= wdog_nxt;
            if (wr_ctrl && din[0] && !finishing) begin
                finishing <= 1'b1;
                fcnt      <= FDLY;
            end else if (finishing && fcnt != '0) begin
                fcnt <= fcnt - 8'd1;
            end
            if (!finish) begin
                if (fin_hit) begin
                    finish <= 1'b1;
                    pass   <= good;
                end else if (wd_hit) begin
                    finish  <= 1'b1;
                    timeout <= 1'b1;
                    pass    <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_n  <= 1'b1;
            firq_n <= 1'b1;
            irq_n  <= 1'b1;
        end else begin
            nmi_n  <= ~sw_nmi;
            firq_n <= ~(sw_firq | (tmr_pend & route));
            irq_n  <= ~(sw_irq | (tmr_pend & ~route));
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            2'd0: dout = {sw_nmi, sw_firq, sw_irq, timeout, tmr_pend, tmr_run, good, finishing};
            2'd1: dout = rld[7:0];
            2'd2: dout = rld[15:8];
            2'd3: dout = {tmr_pend, 4'b0000, route, autorld, tmr_run};
            default: dout = '0;
        endcase
    end
endmodule

// File: tb/tb_jtkcpu_simctrl.sv
// Self-checking bench for jtkcpu_simctrl: randomized bus traffic against
// expectations derived from tick counts and cycle arithmetic.
module tb_jtkcpu_simctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0, cs = 1'b0, we = 1'b0;
    logic [1:0] addr = '0;
    logic [7:0] din = '0;
    logic [7:0] dout, wd_dout;
    logic       nmi_n, firq_n, irq_n, finish, pass, timeout;
    logic       wd_nmi_n, wd_firq_n, wd_irq_n, wd_finish, wd_pass, wd_timeout;
    int         n_pass = 0;
    int         n_total = 0;

    jtkcpu_simctrl #(.FINISH_DLY(20), .TIMEOUT(20000)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .cs(cs), .we(we), .addr(addr), .din(din),
        .dout(dout), .nmi_n(nmi_n), .firq_n(firq_n), .irq_n(irq_n),
        .finish(finish), .pass(pass), .timeout(timeout)
    );

    jtkcpu_simctrl #(.FINISH_DLY(20), .TIMEOUT(100)) dut_wd (
        .clk(clk), .rst_n(rst_n), .cen(cen), .cs(cs), .we(we), .addr(addr), .din(din),
        .dout(wd_dout), .nmi_n(wd_nmi_n), .firq_n(wd_firq_n), .irq_n(wd_irq_n),
        .finish(wd_finish), .pass(wd_pass), .timeout(wd_timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; cen = 1'b1; addr = a; din = d;
        step();
        cs = 1'b0; we = 1'b0; cen = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        cs = 1'b0; we = 1'b0; cen = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        do_reset();
        wr_reg(2'd1, 8'd9);
        wr_reg(2'd3, 8'h03);
        wr_reg(2'd0, 8'hE3);
        cen = 1'b1;
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({nmi_n, firq_n, irq_n, finish, pass, timeout} !== 6'b111000) begin
            $display("FAIL reset_outputs got=%b want=111000", {nmi_n, firq_n, irq_n, finish, pass, timeout});
        end else n_pass++;
        for (int unsigned a = 0; a < 4; a++) begin
            rd(2'(a), d);
            n_total++;
            if (d !== 8'h00) $display("FAIL reset_reg%0d got=%h want=00", a, d);
            else n_pass++;
        end
        cen = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_sw_levels();
        logic [7:0] v, d;
        do_reset();
        for (int unsigned i = 0; i < 10; i++) begin
            v = (i == 0) ? 8'hE0 : (i == 1) ? 8'h00 : 8'($urandom) & 8'hE2;
            wr_reg(2'd0, v);
            rd(2'd0, d);
            n_total++;
            if (d !== v) $display("FAIL sw_readback got=%h want=%h", d, v);
            else n_pass++;
            step();
            n_total++;
            if ({nmi_n, firq_n, irq_n} !== ~v[7:5]) begin
                $display("FAIL sw_levels got=%b want=%b", {nmi_n, firq_n, irq_n}, ~v[7:5]);
            end else n_pass++;
        end
    endtask

    task automatic test_reload_regs();
        logic [7:0] lo, hi, d;
        do_reset();
        for (int unsigned i = 0; i < 4; i++) begin
            lo = 8'($urandom);
            hi = 8'($urandom);
            wr_reg(2'd1, lo);
            wr_reg(2'd2, hi);
            rd(2'd1, d);
            n_total++;
            if (d !== lo) $display("FAIL rld_lo got=%h want=%h", d, lo);
            else n_pass++;
            rd(2'd2, d);
            n_total++;
            if (d !== hi) $display("FAIL rld_hi got=%h want=%h", d, hi);
            else n_pass++;
        end
    endtask

    task automatic test_oneshot();
        logic [7:0] d, want;
        int unsigned r, ticks;
        logic prev_pend, exp_pend;
        for (int unsigned k = 0; k < 3; k++) begin
            r = (k == 0) ? 3 : $urandom_range(6, 1);
            do_reset();
            wr_reg(2'd1, 8'(r));
            wr_reg(2'd2, 8'h00);
            wr_reg(2'd3, 8'h01);
            ticks = 0;
            prev_pend = 1'b0;
            for (int unsigned c = 0; c < 40 && ticks < r + 2; c++) begin
                cen = 1'($urandom);
                if (cen) ticks++;
                step();
                exp_pend = ticks >= r;
                want = {exp_pend, 6'b0, ~exp_pend};
                rd(2'd3, d);
                n_total++;
                if (d !== want) $display("FAIL oneshot_tctrl r=%0d t=%0d got=%h want=%h", r, ticks, d, want);
                else n_pass++;
                n_total++;
                if ({irq_n, firq_n} !== {~prev_pend, 1'b1}) begin
                    $display("FAIL oneshot_irq got=%b want=%b", {irq_n, firq_n}, {~prev_pend, 1'b1});
                end else n_pass++;
                prev_pend = exp_pend;
            end
            cen = 1'b0;
            wr_reg(2'd3, 8'h80);
            step();
            n_total++;
            if (irq_n !== 1'b1) $display("FAIL oneshot_clear got=%b want=1", irq_n);
            else n_pass++;
        end
        // clear write landing on the expiring tick
        do_reset();
        wr_reg(2'd1, 8'd2);
        wr_reg(2'd3, 8'h01);
        cen = 1'b1;
        step();
        wr_reg(2'd3, 8'h80);
        rd(2'd3, d);
        n_total++;
        if (d !== 8'h80) $display("FAIL clear_vs_expire got=%h want=80", d);
        else n_pass++;
        step();
        n_total++;
        if (irq_n !== 1'b0) $display("FAIL clear_vs_expire_irq got=%b want=0", irq_n);
        else n_pass++;
    endtask

    task automatic test_autoreload();
        logic [7:0] d, want;
        int unsigned r, t;
        logic prev_pend, exp_pend;
        r = 2;
        for (int unsigned k = 0; k < 2; k++) begin
            do_reset();
            wr_reg(2'd1, 8'(r));
            wr_reg(2'd3, 8'h07);
            t = 0;
            exp_pend = 1'b0;
            prev_pend = 1'b0;
            for (int unsigned c = 0; c < 40; c++) begin
                if (c % 8 == 7 && exp_pend) begin
                    exp_pend = ((t + 1) % r) == 0;
                    t = 0;
                    wr_reg(2'd3, 8'h87);
                end else begin
                    cen = 1'($urandom);
                    if (cen) begin
                        t++;
                        if (t % r == 0) exp_pend = 1'b1;
                    end
                    step();
                end
                want = {exp_pend, 4'b0, 3'b111};
                rd(2'd3, d);
                n_total++;
                if (d !== want) $display("FAIL autorld_tctrl r=%0d got=%h want=%h", r, d, want);
                else n_pass++;
                n_total++;
                if ({firq_n, irq_n} !== {~prev_pend, 1'b1}) begin
                    $display("FAIL autorld_firq got=%b want=%b", {firq_n, irq_n}, {~prev_pend, 1'b1});
                end else n_pass++;
                prev_pend = exp_pend;
            end
            cen = 1'b0;
            r = $urandom_range(4, 1);
        end
        do_reset();
        wr_reg(2'd1, 8'h00);
        wr_reg(2'd2, 8'h00);
        wr_reg(2'd3, 8'h01);
        rd(2'd3, d);
        n_total++;
        if (d !== 8'h00) $display("FAIL zero_reload got=%h want=00", d);
        else n_pass++;
    endtask

    task automatic run_finish(input logic [7:0] first, input logic [7:0] second, input logic exp_pass);
        int unsigned mid;
        mid = $urandom_range(19, 1);
        do_reset();
        wr_reg(2'd0, first);
        for (int unsigned i = 1; i <= 20; i++) begin
            if (i == mid) wr_reg(2'd0, second);
            else step();
            n_total++;
            if (finish !== (i == 20)) $display("FAIL finish_time edge=%0d got=%b want=%b", i, finish, i == 20);
            else n_pass++;
        end
        n_total++;
        if ({pass, timeout} !== {exp_pass, 1'b0}) begin
            $display("FAIL finish_verdict got=%b want=%b", {pass, timeout}, {exp_pass, 1'b0});
        end else n_pass++;
        wr_reg(2'd0, 8'hE0);
        step();
        n_total++;
        if ({nmi_n, firq_n, irq_n, finish} !== 4'b1111) begin
            $display("FAIL write_after_finish got=%b want=1111", {nmi_n, firq_n, irq_n, finish});
        end else n_pass++;
    endtask

    task automatic test_finish();
        run_finish(8'h03, 8'h03, 1'b1);
        run_finish(8'h01, 8'h01, 1'b0);
        run_finish(8'h03, 8'h01, 1'b0);
        run_finish(8'h01, 8'h03, 1'b1);
    endtask

    task automatic run_watchdog(input int unsigned wr_edge);
        logic normal;
        // a request written at edge W finishes at W+20; landing on 100 beats the watchdog
        normal = wr_edge != 0 && wr_edge + 20 <= 100;
        do_reset();
        for (int unsigned i = 1; i <= 100; i++) begin
            if (i == wr_edge) wr_reg(2'd0, 8'h03);
            else step();
            if (i >= 99) begin
                n_total++;
                if (wd_finish !== (i == 100)) $display("FAIL wd_finish edge=%0d got=%b want=%b", i, wd_finish, i == 100);
                else n_pass++;
            end
        end
        n_total++;
        if ({wd_timeout, wd_pass} !== {~normal, normal}) begin
            $display("FAIL wd_verdict got=%b want=%b", {wd_timeout, wd_pass}, {~normal, normal});
        end else n_pass++;
        n_total++;
        if (finish !== (wr_edge != 0 && wr_edge <= 80)) $display("FAIL wd_long_dut got=%b", finish);
        else n_pass++;
    endtask

    task automatic test_watchdog();
        run_watchdog(0);
        run_watchdog(80);
        run_watchdog(81);
    endtask

    initial begin
        test_reset();
        test_sw_levels();
        test_reload_regs();
        test_oneshot();
        test_autoreload();
        test_finish();
        test_watchdog();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
